// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state/opclass enums, LEGv8 opcode patterns and exception cause codes for multicycle_ctrl
package ctrl_pkg;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, EXC} state_t;
  typedef enum logic [2:0] {C_LDUR, C_STUR, C_CBZ, C_RTYPE, C_ERET, C_MRS, C_INVALID} opclass_t;
  localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
  localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
  localparam logic [10:0] OP_CBZ  = 11'b101_1010_0???;
  localparam logic [10:0] OP_ADD  = 11'b100_0101_1000;
  localparam logic [10:0] OP_SUB  = 11'b110_0101_1000;
  localparam logic [10:0] OP_AND  = 11'b100_0101_0000;
  localparam logic [10:0] OP_ORR  = 11'b101_0101_0000;
  localparam logic [10:0] OP_ERET = 11'b110_1011_0100;
  localparam logic [10:0] OP_MRS  = 11'b110_1010_1001;
  localparam logic [3:0] ES_NONE = 4'b0000;
  localparam logic [3:0] ES_IRQ  = 4'b0001;
  localparam logic [3:0] ES_INV  = 4'b0010;
  localparam logic [3:0] ES_BUS  = 4'b0100;
endpackage

// File: rtl/multicycle_ctrl_opclass_dec.sv
// opclass_dec: combinational Op[10:0] -> opclass_t classifier (cls)
module opclass_dec
  import ctrl_pkg::*;
(
  input  logic [10:0] op,
  output opclass_t    cls
);
  always_comb begin
    cls = C_INVALID;
    casez (op)
      OP_LDUR: cls = C_LDUR;
      OP_STUR: cls = C_STUR;
      OP_CBZ: cls = C_CBZ;
      OP_ADD, OP_SUB, OP_AND, OP_ORR: cls = C_RTYPE;
      OP_ERET: cls = C_ERET;
      OP_MRS: cls = C_MRS;
      default: cls = C_INVALID;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: LEGv8 multi-cycle control FSM; in clk/reset(async low)/Op/irq/im_ready/dm_ready, out datapath controls, Exc, EStatus
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter bit IRQ_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] Op,
  input  logic        irq,
  input  logic        im_ready,
  input  logic        dm_ready,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        Reg2Loc,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Branch,
  output logic        ERet,
  output logic [1:0]  ALUSrc,
  output logic [1:0]  ALUOp,
  output logic        Exc,
  output logic [3:0]  EStatus
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  state_t state_q, state_d;
  opclass_t cls_q, cls_d, dec_cls;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] es_q, es_d;
  logic ready, expired, take_irq, ldst;
  opclass_dec u_dec (.op(Op), .cls(dec_cls));
  assign ready = (state_q == FETCH) ? im_ready : dm_ready;
  assign expired = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT)) && !ready;
  assign take_irq = irq && IRQ_EN;
  assign ldst = (cls_q == C_LDUR) || (cls_q == C_STUR);
  always_comb begin
    state_d = state_q;
    cls_d = cls_q;
    es_d = es_q;
    cnt_d = ready ? cnt_q : cnt_q + 1'b1;
    case (state_q)
      FETCH: begin
        state_d = im_ready ? DECODE : expired ? EXC : FETCH;
        es_d = (!im_ready && expired) ? ES_BUS : es_q;
      end
      DECODE: begin
        cls_d = dec_cls;
        state_d = (dec_cls == C_INVALID || take_irq) ? EXC : EXEC;
        es_d = (dec_cls == C_INVALID) ? ES_INV : take_irq ? ES_IRQ : es_q;
      end
      EXEC: begin
        state_d = ldst ? MEM : (cls_q == C_RTYPE || cls_q == C_MRS) ? WB : FETCH;
        es_d = (cls_q == C_ERET) ? ES_NONE : es_q;
      end
      MEM: begin
        state_d = dm_ready ? ((cls_q == C_LDUR) ? WB : FETCH) : expired ? EXC : MEM;
        es_d = (!dm_ready && expired) ? ES_BUS : es_q;
      end
      default: state_d = FETCH;
    endcase
    if (state_d != state_q && (state_d == FETCH || state_d == MEM)) cnt_d = '0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      cls_q <= C_INVALID;
      cnt_q <= '0;
      es_q <= ES_NONE;
    end else begin
      state_q <= state_d;
      cls_q <= cls_d;
      cnt_q <= cnt_d;
      es_q <= es_d;
    end
  end
  assign IRWrite = reset && (state_q == FETCH) && im_ready;
  assign PCWrite = IRWrite;
  assign Reg2Loc = (state_q == EXEC && (cls_q == C_MRS || cls_q == C_CBZ)) || (state_q == MEM && cls_q == C_STUR);
  assign MemtoReg = (state_q == WB) && (cls_q == C_LDUR);
  assign RegWrite = (state_q == WB);
  assign MemRead = (state_q == MEM) && (cls_q == C_LDUR);
  assign MemWrite = (state_q == MEM) && (cls_q == C_STUR);
  assign Branch = (state_q == EXEC) && (cls_q == C_CBZ || cls_q == C_ERET);
  assign ERet = (state_q == EXEC) && (cls_q == C_ERET);
  assign ALUSrc = (state_q != EXEC) ? 2'b00 : ldst ? 2'b01 : (cls_q == C_MRS) ? 2'b10 : 2'b00;
  assign ALUOp = (state_q != EXEC) ? 2'b00 : (cls_q == C_RTYPE) ? 2'b10 :
                 (cls_q == C_MRS || cls_q == C_CBZ || cls_q == C_ERET) ? 2'b01 : 2'b00;
  assign Exc = (state_q == EXC);
  assign EStatus = es_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: instruction-level model of multicycle_ctrl expanded to per-cycle expectations
module tb_multicycle_ctrl;
  localparam int T = 4;
  localparam int K_LD = 0, K_ST = 1, K_CBZ = 2, K_R = 3, K_ERET = 4, K_MRS = 5, K_INV = 6;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [10:0] Op = '0;
  logic irq = 1'b0, im_ready = 1'b0, dm_ready = 1'b0;
  logic IRWrite, PCWrite, Reg2Loc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ERet, Exc;
  logic [1:0] ALUSrc, ALUOp;
  logic [3:0] EStatus;
  logic [17:0] act;
  typedef struct packed {logic imr; logic dmr; logic irqv; logic [10:0] op; logic [17:0] want;} cyc_t;
  cyc_t sq[$];
  logic [17:0] obs [0:63];
  logic [3:0] es = 4'b0000;
  logic [10:0] cur_op = '0;
  int nchk = 0, nfail = 0, len = 0, cnt = 0;
  string tag = "reset";
  multicycle_ctrl #(.TIMEOUT(T), .IRQ_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .Op(Op), .irq(irq), .im_ready(im_ready), .dm_ready(dm_ready),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .Reg2Loc(Reg2Loc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .ERet(ERet), .ALUSrc(ALUSrc),
    .ALUOp(ALUOp), .Exc(Exc), .EStatus(EStatus)
  );
  always #5 clk = ~clk;
  assign act = {IRWrite, PCWrite, Reg2Loc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ERet,
                ALUSrc, ALUOp, Exc, EStatus};
  task automatic check(input string nm, input logic [17:0] got, input logic [17:0] want);
    nchk++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s [%s]: got %b expected %b", nm, tag, got, want);
    end
  endtask
  function automatic int kind(input logic [10:0] op);
    if (op == 11'b11111000010) return K_LD;
    if (op == 11'b11111000000) return K_ST;
    if (op[10:3] == 8'b10110100) return K_CBZ;
    if (op == 11'b10001011000 || op == 11'b11001011000 || op == 11'b10001010000 || op == 11'b10101010000) return K_R;
    if (op == 11'b11010110100) return K_ERET;
    if (op == 11'b11010101001) return K_MRS;
    return K_INV;
  endfunction
  function automatic logic [17:0] ev(input logic irw, r2l, m2r, rw, mr, mw, br, er,
                                     input logic [1:0] src, aop, input logic exc);
    return {irw, irw, r2l, m2r, rw, mr, mw, br, er, src, aop, exc, es};
  endfunction
  function automatic logic [17:0] idle();
    return ev(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
  endfunction
  function automatic logic [17:0] exc_v();
    return ev(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1);
  endfunction
  function automatic void push(input logic imr, dmr, irqv, input logic [17:0] w);
    sq.push_back('{imr, dmr, irqv, cur_op, w});
  endfunction
  task automatic mem_phase(input bit ld, input int dmw, input logic irqv);
    logic [17:0] w;
    w = ld ? ev(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0) : ev(0, 1, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0);
    if (T != 0 && dmw > T) begin
      for (int i = 0; i <= T; i++) push(0, 0, irqv, w);
      es = 4'b0100;
      push(0, 0, irqv, exc_v());
    end else begin
      repeat (dmw) push(0, 0, irqv, w);
      push(0, 1, irqv, w);
      if (ld) push(0, 0, irqv, ev(0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0));
    end
  endtask
  task automatic gen(input logic [10:0] op, input logic irq_f, irq_d, input int imw, dmw, output int n);
    int n0;
    int k;
    n0 = sq.size();
    cur_op = op;
    k = kind(op);
    if (T != 0 && imw > T) begin
      for (int i = 0; i <= T; i++) push(0, 0, irq_f, idle());
      es = 4'b0100;
      push(0, 0, irq_f, exc_v());
    end else begin
      repeat (imw) push(0, 0, irq_f, idle());
      push(1, 0, irq_f, ev(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
      push(0, 0, irq_d, idle());
      if (k == K_INV || irq_d) begin
        es = (k == K_INV) ? 4'b0010 : 4'b0001;
        push(0, 0, irq_d, exc_v());
      end else if (k == K_LD || k == K_ST) begin
        push(0, 0, irq_d, ev(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0));
        mem_phase(k == K_LD, dmw, irq_d);
      end else if (k == K_R) begin
        push(0, 0, irq_d, ev(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0));
        push(0, 0, irq_d, ev(0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0));
      end else if (k == K_MRS) begin
        push(0, 0, irq_d, ev(0, 1, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 0));
        push(0, 0, irq_d, ev(0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0));
      end else if (k == K_CBZ) begin
        push(0, 0, irq_d, ev(0, 1, 0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 0));
      end else begin
        push(0, 0, irq_d, ev(0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b01, 0));
        es = 4'b0000;
      end
    end
    n = sq.size() - n0;
  endtask
  task automatic run(input int n);
    int k;
    k = 0;
    while (sq.size() > 0 && (n < 0 || k < n)) begin
      cyc_t c;
      c = sq.pop_front();
      im_ready = c.imr;
      dm_ready = c.dmr;
      irq = c.irqv;
      Op = c.op;
      @(negedge clk);
      check($sformatf("cycle%0d", k), act, c.want);
      if (k < 64) obs[k] = act;
      k++;
      @(posedge clk);
      #1;
    end
  endtask
  task automatic go(input string nm, input logic [10:0] op, input logic irq_f, irq_d, input int imw, dmw, expect_len);
    tag = nm;
    gen(op, irq_f, irq_d, imw, dmw, len);
    check("model_len", 18'(len), 18'(expect_len));
    run(-1);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", act, 18'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    go("add", 11'b10001011000, 0, 0, 0, 0, 4);
    check("add_irwrite_c0", 18'(obs[0][17]), 18'd1);
    check("add_aluop_c2", 18'(obs[2][6:5]), 18'd2);
    check("add_regwrite_c2", 18'(obs[2][13]), 18'd0);
    check("add_regwrite_c3", 18'(obs[3][13]), 18'd1);
    go("ldur_wait3", 11'b11111000010, 0, 0, 0, 3, 8);
    cnt = 0;
    for (int i = 0; i < 8; i++) cnt += int'(obs[i][12]);
    check("ldur_memread_cycles", 18'(cnt), 18'd4);
    check("ldur_wb", 18'(obs[7][14:13]), 18'b11);
    go("ldur", 11'b11111000010, 0, 0, 0, 0, 5);
    go("stur", 11'b11111000000, 0, 0, 0, 0, 4);
    go("cbz", 11'b10110100101, 0, 0, 0, 0, 3);
    go("sub", 11'b11001011000, 0, 0, 1, 0, 5);
    go("and", 11'b10001010000, 0, 0, 0, 0, 4);
    go("orr", 11'b10101010000, 0, 0, 0, 0, 4);
    go("mrs", 11'b11010101001, 0, 0, 0, 0, 4);
    go("invalid_irq", 11'b00000000000, 1, 1, 0, 0, 3);
    check("inv_estatus", 18'(obs[2][4:0]), 18'b10010);
    go("irq", 11'b10001011000, 1, 1, 0, 0, 3);
    check("irq_estatus", 18'(obs[2][4:0]), 18'b10001);
    go("eret", 11'b11010110100, 0, 0, 0, 0, 3);
    check("eret_branch", 18'(obs[2][10:9]), 18'b11);
    go("after_eret", 11'b10001011000, 0, 0, 0, 0, 4);
    check("eret_cleared", 18'(obs[0][3:0]), 18'd0);
    go("irq_dropped", 11'b10001011000, 1, 0, 2, 0, 6);
    go("im_timeout", 11'b10001011000, 0, 0, 5, 0, 6);
    check("imto_exc_c5", 18'(obs[5][4:0]), 18'b10100);
    cnt = 0;
    for (int i = 0; i < 6; i++) cnt += int'(obs[i][17]);
    check("imto_no_irwrite", 18'(cnt), 18'd0);
    go("im_edge_ok", 11'b10001011000, 0, 0, 4, 0, 8);
    check("im_edge_irwrite", 18'(obs[4][17]), 18'd1);
    go("dm_timeout", 11'b11111000000, 0, 0, 0, 5, 9);
    check("dmto_exc", 18'(obs[8][4:0]), 18'b10100);
    go("dm_edge_ok", 11'b11111000010, 0, 0, 0, 4, 9);
    tag = "reset_mid_mem";
    gen(11'b11111000000, 0, 0, 0, 3, len);
    run(4);
    im_ready = 1'b0;
    dm_ready = 1'b0;
    #2;
    check("memwrite_before_reset", 18'(MemWrite), 18'd1);
    reset = 1'b0;
    #1;
    check("async_reset_outputs", act, 18'b0);
    sq.delete();
    es = 4'b0000;
    @(posedge clk);
    #1;
    reset = 1'b1;
    go("post_reset_add", 11'b10001011000, 0, 0, 0, 0, 4);
    check("post_reset_irwrite", 18'(obs[0][17]), 18'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
